ysyx_23060201_isram: RTL and testbench
======================================

YSYX_23060201_ISRAM -- requirements
Module: ysyx_23060201_isram

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 32, meaning request address width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 32, meaning response data width.
REQ-003 The block SHALL expose parameter LATENCY, default 1, legal range 1..15, meaning the minimum number of cycles from request acceptance to rvalid.
REQ-004 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, is the reset; reset is synchronous and active-high.
REQ-006 Port arvalid, input, 1, SHALL mean the fetch initiator presents a read request.
REQ-007 Port arready, output, 1, SHALL mean the responder can accept a request this cycle.
REQ-008 Port araddr, input, ADDR_WIDTH, SHALL carry the fetch byte address.
REQ-009 Port rvalid, output, 1, SHALL mean rdata and rresp are valid.
REQ-010 Port rready, input, 1, SHALL mean the initiator accepts the response this cycle.
REQ-011 Port rdata, output, DATA_WIDTH, SHALL carry the instruction word.
REQ-012 Port rresp, output, 1, SHALL be 0 for OKAY and 1 for access error.

Function
REQ-013 The block SHALL implement three states: IDLE, WAIT, RESP; exactly one request SHALL be outstanding at a time.
REQ-014 In IDLE: arready=1, rvalid=0. On arvalid&&arready the block SHALL latch araddr, load count=LATENCY-1 and enter WAIT at that edge.
REQ-015 In WAIT: arready=0, rvalid=0. Each edge with count!=0 SHALL decrement count; the edge with count==0 SHALL capture the response into rdata/rresp and enter RESP.
REQ-016 With LATENCY=1, a request accepted at edge N SHALL show rvalid=1 after edge N+1.
REQ-017 Data capture SHALL call DPI pmem_read with the latched address only when that address is >= `MBASE and araddr[1:0]==0; rresp=0 in that case.
REQ-018 Addresses below `MBASE or misaligned SHALL NOT invoke pmem_read; rdata=0, rresp=1.
REQ-019 In RESP: arready=0, rvalid=1; rdata and rresp SHALL remain stable until rvalid&&rready.
REQ-020 On rvalid&&rready the block SHALL return to IDLE; arready=1 in the following cycle (no same-cycle re-acceptance).
REQ-021 arvalid asserted outside IDLE SHALL be ignored; araddr changes after acceptance SHALL NOT affect the response.
REQ-022 rready asserted while rvalid=0 SHALL have no effect.

Reset
REQ-023 While rst=1 at a rising edge: state=IDLE, count=0, rdata=0, rresp=0, rvalid=0; arready SHALL be 1 in the cycle after reset release.
REQ-024 Reset asserted in WAIT or RESP SHALL abort the transaction; no response SHALL be delivered for it.

Configuration
REQ-025 Macro ISRAM_RAND_DELAY_EN SHALL, when defined, add an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advancing every non-reset cycle); on acceptance, count SHALL load LATENCY-1+lfsr[1:0].
REQ-026 Without ISRAM_RAND_DELAY_EN, no LFSR SHALL exist and latency SHALL be exactly LATENCY cycles.

Verification
REQ-027 LATENCY=1, pmem[0x80000000]=0x00000413, arvalid with araddr=0x80000000 at edge N, rready=1 -> rvalid=1 with rdata=0x00000413, rresp=0 after edge N+1; arready=1 after edge N+2.
REQ-028 LATENCY=3, request accepted at edge N -> rvalid stays 0 through edge N+2 and asserts after edge N+3.
REQ-029 araddr=0x00001000 -> rdata=0, rresp=1, no pmem_read call; araddr=0x80000002 -> rdata=0, rresp=1.
REQ-030 rready held 0 for 5 cycles in RESP -> rvalid, rdata, rresp constant for all 5 cycles; arvalid pulses in those cycles are not accepted.
REQ-031 rst=1 during WAIT -> after release, state IDLE, rvalid=0, arready=1, and no response is delivered for the aborted request.
REQ-032 ISRAM_RAND_DELAY_EN defined, LATENCY=1, 100 back-to-back fetches -> every latency within 1..4 cycles and all rdata values correct.

Source files
------------

// File: rtl/ysyx_23060201_isram.sv
// Instruction fetch responder: one outstanding read, fixed LATENCY-cycle response, error on low/misaligned address.
// Optional macro ISRAM_RAND_DELAY_EN adds 0..3 cycles of LFSR-driven extra latency per request.
`ifndef MBASE
`define MBASE 32'h8000_0000
`endif

module ysyx_23060201_isram #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rresp
);

  localparam int unsigned CNT_W = 5;
  localparam logic [ADDR_WIDTH-1:0] MBASE_A = ADDR_WIDTH'(`MBASE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  rresp_d;
  logic                  addr_ok;
  logic [CNT_W-1:0]      extra;

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running outside reset
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign extra = CNT_W'(lfsr[1:0]);
`else
  assign extra = '0;
`endif

  // Physical-memory image read; only reached for in-range, word-aligned addresses
  function automatic logic [DATA_WIDTH-1:0] pmem_read(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - MBASE_A;
    case (off)
      ADDR_WIDTH'(0):  pmem_read = DATA_WIDTH'(32'h0000_0413);
      ADDR_WIDTH'(4):  pmem_read = DATA_WIDTH'(32'h0000_9117);
      ADDR_WIDTH'(8):  pmem_read = DATA_WIDTH'(32'hffc1_0113);
      ADDR_WIDTH'(12): pmem_read = DATA_WIDTH'(32'h00c0_00ef);
      ADDR_WIDTH'(16): pmem_read = DATA_WIDTH'(32'h0000_0513);
      ADDR_WIDTH'(20): pmem_read = DATA_WIDTH'(32'h0010_0073);
      ADDR_WIDTH'(24): pmem_read = DATA_WIDTH'(32'hff01_0113);
      ADDR_WIDTH'(28): pmem_read = DATA_WIDTH'(32'h0000_0517);
      default:         pmem_read = '0;
    endcase
  endfunction

  assign addr_ok = (addr_q >= MBASE_A) && (addr_q[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      rdata   <= '0;
      rresp   <= 1'b0;
      rvalid  <= 1'b0;
      arready <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
      rvalid  <= (state_d == S_RESP);
      arready <= (state_d == S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    rdata_d = rdata;
    rresp_d = rresp;
    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          addr_d  = araddr;
          count_d = CNT_W'(LATENCY - 1) + extra;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          state_d = S_RESP;
          if (addr_ok) begin
            rdata_d = pmem_read(addr_q);
            rresp_d = 1'b0;
          end else begin
            rdata_d = '0;
            rresp_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060201_isram.sv
// Directed bench for ysyx_23060201_isram: a LATENCY=1 and a LATENCY=3 instance, selected by sel.
module tb_ysyx_23060201_isram;

`ifdef ISRAM_RAND_DELAY_EN
  localparam int EX = 3;
`else
  localparam int EX = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arvalid, rready, sel;
  logic [31:0] araddr;
  logic        av1, rr1, av3, rr3;
  logic        ar1, rv1, rs1, ar3, rv3, rs3;
  logic [31:0] rd1, rd3;
  logic        o_arready, o_rvalid, o_rresp;
  logic [31:0] o_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] img [8] = '{32'h0000_0413, 32'h0000_9117, 32'hffc1_0113, 32'h00c0_00ef,
                           32'h0000_0513, 32'h0010_0073, 32'hff01_0113, 32'h0000_0517};

  ysyx_23060201_isram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .arvalid(av1), .arready(ar1), .araddr(araddr),
    .rvalid(rv1), .rready(rr1), .rdata(rd1), .rresp(rs1));

  ysyx_23060201_isram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .arvalid(av3), .arready(ar3), .araddr(araddr),
    .rvalid(rv3), .rready(rr3), .rdata(rd3), .rresp(rs3));

  always_comb begin
    av1 = arvalid && !sel;
    rr1 = rready && !sel;
    av3 = arvalid && sel;
    rr3 = rready && sel;
    o_arready = sel ? ar3 : ar1;
    o_rvalid  = sel ? rv3 : rv1;
    o_rresp   = sel ? rs3 : rs1;
    o_rdata   = sel ? rd3 : rd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait (bounded) for rvalid, check payload; hs=1 completes the handshake.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_r,
                       input int lmin, input int lmax, input logic hs);
    int lat;
    lat = 0;
    arvalid = 1'b1;
    araddr  = addr;
    tick();
    arvalid = 1'b0;
    araddr  = 32'h0000_1000;
    check("accept_arready", 32'(o_arready), 32'd0);
    while (!o_rvalid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency_in_range", 32'(lat >= lmin && lat <= lmax), 32'd1);
    check("rdata", o_rdata, exp_d);
    check("rresp", 32'(o_rresp), 32'(exp_r));
    if (hs) begin
      tick();
      check("rvalid_drop", 32'(o_rvalid), 32'd0);
      check("arready_back", 32'(o_arready), 32'd1);
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; arvalid = 1'b0; rready = 1'b0; araddr = 32'h0;
    tick();
    tick();
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_rresp", 32'(o_rresp), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_arready", 32'(o_arready), 32'd1);
    check("post_rst_rvalid", 32'(o_rvalid), 32'd0);

    // rready while idle does nothing
    rready = 1'b1;
    tick();
    check("idle_rready_rvalid", 32'(o_rvalid), 32'd0);
    check("idle_rready_arready", 32'(o_arready), 32'd1);

    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 1, 1 + EX, 1'b1);
    fetch(32'h8000_0004, 32'h0000_9117, 1'b0, 1, 1 + EX, 1'b1);
    fetch(32'h0000_1000, 32'h0000_0000, 1'b1, 1, 1 + EX, 1'b1);
    fetch(32'h8000_0002, 32'h0000_0000, 1'b1, 1, 1 + EX, 1'b1);
    fetch(32'h7fff_fffc, 32'h0000_0000, 1'b1, 1, 1 + EX, 1'b1);

    // Response held under backpressure; arvalid pulses must be ignored
    rready = 1'b0;
    fetch(32'h8000_0008, 32'hffc1_0113, 1'b0, 1, 1 + EX, 1'b0);
    for (int i = 0; i < 5; i++) begin
      arvalid = (i % 2 == 0);
      araddr  = 32'h8000_0000;
      tick();
      check("hold_rvalid", 32'(o_rvalid), 32'd1);
      check("hold_rdata", o_rdata, 32'hffc1_0113);
      check("hold_rresp", 32'(o_rresp), 32'd0);
      check("hold_arready", 32'(o_arready), 32'd0);
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    tick();
    check("hold_release_rvalid", 32'(o_rvalid), 32'd0);
    check("hold_release_arready", 32'(o_arready), 32'd1);
    tick();
    check("no_stray_accept", 32'(o_arready), 32'd1);

    // Reset during WAIT aborts the request
    sel = 1'b1;
    arvalid = 1'b1;
    araddr  = 32'h8000_0000;
    tick();
    arvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rvalid", 32'(o_rvalid), 32'd0);
    check("abort_arready", 32'(o_arready), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("abort_no_resp", 32'(o_rvalid), 32'd0);
    end

    fetch(32'h8000_000c, 32'h00c0_00ef, 1'b0, 3, 3 + EX, 1'b1);
    fetch(32'h8000_0010, 32'h0000_0513, 1'b0, 3, 3 + EX, 1'b1);

    // Back-to-back fetches over the whole image
    sel = 1'b0;
    for (int i = 0; i < 100; i++) begin
      fetch(32'h8000_0000 + 32'(4 * (i % 8)), img[i % 8], 1'b0, 1, 1 + EX, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
